// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths and write-back source encoding for the rv64 core
package rv64_pkg;
    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU,
        WB_MDU
    } wb_src_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: result sources, scoreboard control and register-file write port
interface wb_arbiter_if;
    import rv64_pkg::*;

    logic                  alu_valid_i;
    logic [REG_ADDR_W-1:0] alu_rd_i;
    logic [XLEN-1:0]       alu_data_i;
    logic                  lsu_valid_i;
    logic                  lsu_ready_o;
    logic [REG_ADDR_W-1:0] lsu_rd_i;
    logic [XLEN-1:0]       lsu_data_i;
    logic                  mdu_valid_i;
    logic                  mdu_ready_o;
    logic [REG_ADDR_W-1:0] mdu_rd_i;
    logic [XLEN-1:0]       mdu_data_i;
    logic                  mark_valid_i;
    logic [REG_ADDR_W-1:0] mark_rd_i;
    logic                  flush_i;
    logic [REG_ADDR_W-1:0] rs1_addr_i;
    logic                  rs1_busy_o;
    logic [REG_ADDR_W-1:0] rs2_addr_i;
    logic                  rs2_busy_o;
    logic                  rd_wen_o;
    logic [REG_ADDR_W-1:0] rd_addr_o;
    logic [XLEN-1:0]       rd_data_o;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        output lsu_ready_o,
        input  mdu_valid_i, mdu_rd_i, mdu_data_i,
        output mdu_ready_o,
        input  mark_valid_i, mark_rd_i, flush_i,
        input  rs1_addr_i, rs2_addr_i,
        output rs1_busy_o, rs2_busy_o,
        output rd_wen_o, rd_addr_o, rd_data_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  lsu_ready_o,
        output mdu_valid_i, mdu_rd_i, mdu_data_i,
        input  mdu_ready_o,
        output mark_valid_i, mark_rd_i, flush_i,
        output rs1_addr_i, rs2_addr_i,
        input  rs1_busy_o, rs2_busy_o,
        input  rd_wen_o, rd_addr_o, rd_data_o
    );
endinterface

// File: rtl/wb_arbiter_scoreboard.sv
// wb_scoreboard: pending-write busy vector with mark/clear/flush and two hazard query ports
module wb_scoreboard
    import rv64_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mark_valid,
    input  logic [REG_ADDR_W-1:0] mark_rd,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    // x0 is never tracked; the set is applied after the clear so a same-cycle mark survives
    always_comb begin
        set_mask = (mark_valid && |mark_rd) ? (NREG'(1) << mark_rd) : '0;
        clr_mask = clr_valid ? (NREG'(1) << clr_rd) : '0;
        busy_d   = flush ? '0 : ((busy_q & ~clr_mask) | set_mask);
    end

    // busy vector register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign rs1_busy = busy_q[rs1_addr] && |rs1_addr;
    assign rs2_busy = busy_q[rs2_addr] && |rs2_addr;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU/LSU/MDU results into one registered register-file write per cycle
module wb_arbiter
    import rv64_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    logic                  rr_q;
    logic                  lsu_ready;
    logic                  mdu_ready;
    wb_src_e               grant;
    wb_src_e               src_q;
    logic [REG_ADDR_W-1:0] rd_addr_d;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic [XLEN-1:0]       rd_data_d;
    logic [XLEN-1:0]       rd_data_q;

    // ALU always wins; LSU and MDU share the leftover slot round-robin, flush blocks both
    always_comb begin
        lsu_ready = !bus.alu_valid_i && !bus.flush_i && (!rr_q || !bus.mdu_valid_i);
        mdu_ready = !bus.alu_valid_i && !bus.flush_i && (rr_q || !bus.lsu_valid_i);
        grant     = bus.alu_valid_i                ? WB_ALU :
                    (bus.lsu_valid_i && lsu_ready) ? WB_LSU :
                    (bus.mdu_valid_i && mdu_ready) ? WB_MDU : WB_NONE;
        rd_addr_d = (grant == WB_ALU) ? bus.alu_rd_i :
                    (grant == WB_LSU) ? bus.lsu_rd_i : bus.mdu_rd_i;
        rd_data_d = (grant == WB_ALU) ? bus.alu_data_i :
                    (grant == WB_LSU) ? bus.lsu_data_i : bus.mdu_data_i;
    end

    // output register and round-robin pointer; address/data hold when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= WB_NONE;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            rr_q      <= 1'b0;
        end else begin
            src_q <= grant;
            if (grant != WB_NONE) begin
                rd_addr_q <= rd_addr_d;
                rd_data_q <= rd_data_d;
            end
            if (grant == WB_LSU)      rr_q <= 1'b1;
            else if (grant == WB_MDU) rr_q <= 1'b0;
        end
    end

    assign bus.lsu_ready_o = lsu_ready;
    assign bus.mdu_ready_o = mdu_ready;
    assign bus.rd_wen_o    = (src_q != WB_NONE) && |rd_addr_q;
    assign bus.rd_addr_o   = rd_addr_q;
    assign bus.rd_data_o   = rd_data_q;

    // busy clears off the output register so the drop lines up with register-file visibility
    wb_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .mark_valid (bus.mark_valid_i),
        .mark_rd    (bus.mark_rd_i),
        .clr_valid  (src_q == WB_LSU || src_q == WB_MDU),
        .clr_rd     (rd_addr_q),
        .flush      (bus.flush_i),
        .rs1_addr   (bus.rs1_addr_i),
        .rs2_addr   (bus.rs2_addr_i),
        .rs1_busy   (bus.rs1_busy_o),
        .rs2_busy   (bus.rs2_busy_o)
    );
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and pending-write scoreboard that owns the single register-file write port. It merges results from the single-cycle ALU, the load/store unit (LSU) and the multi-cycle mul/div unit (MDU) into one registered write per cycle. It also tracks destination registers of in-flight long-latency operations so that issue logic can detect RAW hazards.

## Interface
- XLEN, 64, data width of results and write port
- NREG, 32, architectural register count (address width = $clog2(NREG) = 5)

- clk  in  1  core clock
- rst_n  in  1  reset: asynchronous, active-low
- alu_valid_i  in  1  ALU result valid; always accepted, no ready
- alu_rd_i  in  5  ALU destination register
- alu_data_i  in  XLEN  ALU result
- lsu_valid_i  in  1  load result valid
- lsu_ready_o  out  1  load result accepted this cycle
- lsu_rd_i  in  5  load destination register
- lsu_data_i  in  XLEN  load result
- mdu_valid_i  in  1  mul/div result valid
- mdu_ready_o  out  1  mul/div result accepted this cycle
- mdu_rd_i  in  5  mul/div destination register
- mdu_data_i  in  XLEN  mul/div result
- mark_valid_i  in  1  long-latency op issued; set busy bit
- mark_rd_i  in  5  destination of the issued op
- flush_i  in  1  pipeline flush
- rs1_addr_i  in  5  hazard query address 1
- rs1_busy_o  out  1  rs1 has a pending write
- rs2_addr_i  in  5  hazard query address 2
- rs2_busy_o  out  1  rs2 has a pending write
- rd_wen_o  out  1  register-file write enable
- rd_addr_o  out  5  register-file write address
- rd_data_o  out  XLEN  register-file write data

## Operation
- Grant priority: ALU is absolute. LSU and MDU share the remaining slot round-robin via rr_q (0 = LSU preferred).
- Transfer: ALU whenever alu_valid_i=1. LSU/MDU when valid && ready.
- lsu_ready_o = !alu_valid_i && !flush_i && (rr_q==0 || !mdu_valid_i). mdu_ready_o is symmetric with rr_q==1 || !lsu_valid_i.
- Ready is combinational from valid. Sources must never make valid depend on ready.
- rr_q update: on an LSU grant rr_q<=1; on an MDU grant rr_q<=0; otherwise hold.
- Writes with rd=0 complete the handshake but produce rd_wen_o=0.
- Scoreboard: 32-bit busy vector.
  - mark_valid_i sets busy[mark_rd_i]; mark with rd=0 is ignored.
  - A completed LSU/MDU write clears busy[rd]. ALU writes never touch busy.
  - Set and clear of the same register in the same cycle: set wins.
- rsN_busy_o = busy[rsN_addr_i]. Output is combinational and always 0 for address 0.
- flush_i:
  - Clears the entire busy vector at the next edge; a concurrent mark is ignored.
  - Forces lsu_ready_o and mdu_ready_o to 0.
  - ALU writes still pass.
  - A write already in the output register still completes.

## Timing
- Reset values: rd_wen_o=0, rd_addr_o=0, rd_data_o=0, busy=0, rr_q=0. Ready outputs then follow their equations.
- Latency: a transfer accepted in cycle N appears on rd_* in cycle N+1. The register file captures it at the end of N+1, and the value is readable in N+2.
- Busy clear is registered on the same timeline: the bit drops in cycle N+2, aligned with register-file visibility.
- Mark in cycle N makes busy visible in cycle N+1.
- Throughput: one write per cycle. With the ALU valid every cycle, LSU and MDU stall indefinitely; this is accepted by design.
- rd_wen_o is 0 in any cycle following a no-grant cycle.
- Reset mid-operation: all state clears asynchronously. Pending LSU/MDU results remain held by their sources.

## Structure
- rv64_pkg holds:
  - XLEN and REG_ADDR_W constants.
  - wb_src_e enum {WB_NONE, WB_ALU, WB_LSU, WB_MDU}, used for the internal grant select.
- Sub-module wb_scoreboard: busy vector, set/clear/flush logic and the two query ports.
- The grant logic and output register stay in wb_arbiter.

## Test plan
- ALU only, rd=5, data=0xDEAD in cycle 0 -> rd_wen_o=1, rd_addr_o=5, rd_data_o=0xDEAD in cycle 1. Nothing is written in cycle 2.
- ALU, LSU and MDU all valid for 3 cycles, ALU drops in cycle 2 -> cycles 0-1: ALU granted, both readies 0. Cycle 2: LSU granted. Cycle 3: MDU granted.
- LSU and MDU held valid continuously with no ALU -> grants alternate LSU, MDU, LSU, MDU with no idle cycles.
- Sequence:
  - Mark rd=7 in cycle 0 -> rs1_busy_o=1 for rs1_addr_i=7 from cycle 1.
  - MDU writes rd=7 in cycle 4 -> busy reads 0 from cycle 6.
  - Same-cycle mark and clear of rd=7 -> busy remains 1.
- MDU result rd=0 accepted -> mdu_ready_o=1 and rd_wen_o=0 next cycle. Mark rd=0 -> busy never asserted.
- Marks for rd=3 and rd=9, then flush_i with LSU valid and a mark of rd=4 in the same cycle:
  - lsu_ready_o=0 during the flush.
  - All busy bits read 0 next cycle, including rd=4.
- Reset asserted mid-stream -> outputs and busy clear immediately.
